// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The frame_cycles helper gives the transmitter frame length used to size TIMEOUT.
package uart_tx_arbiter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Cycles for one transmitter frame (start + data + parity + stop bits), CLOCK = cycles per bit.
    function automatic int frame_cycles(input int data_size, input int clock);
        return (data_size + 3) * clock;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client and transmitter signals seen by the arbiter.
// master = arbiter view, slave = clients plus transmitter view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           ack;
    logic                         err;
    logic                         busy;
    logic [ID_W-1:0]              grant_id;
    logic [DATA_SIZE-1:0]         tx_din;
    logic                         tx_send_req;
    logic                         tx_send_ack;

    modport master (
        input  req, req_data, tx_send_ack,
        output ack, err, busy, grant_id, tx_din, tx_send_req
    );

    modport slave (
        output req, req_data, tx_send_ack,
        input  ack, err, busy, grant_id, tx_din, tx_send_req
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests so the slot after 'last' is bit 0,
// find the first set bit, then rotate the index back.
module rr_priority_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    idx
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        start;
    logic [ID_W:0]        off;
    logic [ID_W:0]        sum;

    always_comb begin
        any   = |req;
        dbl   = {req, req};
        start = {1'b0, last} + (ID_W+1)'(1);
        rot   = NUM_REQ'(dbl >> start);
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (ID_W+1)'(i);
        end
        sum = start + off;
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        idx = sum[ID_W-1:0];
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ clients,
// with a watchdog that aborts a frame whose send_ack never arrives.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT   = 1048575,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int TMO_W     = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_RESET = ID_W'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [DATA_SIZE-1:0] tx_din_q, tx_din_d;
    logic                 tx_send_req_q, tx_send_req_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [TMO_W-1:0]     watchdog_q, watchdog_d;

    logic                 pick_any;
    logic [ID_W-1:0]      pick_idx;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req  (bus.req),
        .last (grant_id_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        tx_din_d      = tx_din_q;
        tx_send_req_d = 1'b0;
        ack_d         = '0;
        err_d         = 1'b0;
        watchdog_d    = watchdog_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d    = pick_idx;
                    tx_din_d      = bus.req_data[pick_idx*DATA_SIZE +: DATA_SIZE];
                    tx_send_req_d = 1'b1;
                    state_d       = LAUNCH;
                end
            end
            LAUNCH: begin
                watchdog_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                watchdog_d = watchdog_q + TMO_W'(1);
                // A genuine ack takes precedence over a coincident expiry.
                if (bus.tx_send_ack) begin
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = DONE;
                end else if (watchdog_q == TMO_LAST) begin
                    ack_d[grant_id_q] = 1'b1;
                    err_d             = 1'b1;
                    state_d           = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_id_q    <= ID_RESET;
            tx_din_q      <= '0;
            tx_send_req_q <= 1'b0;
            ack_q         <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            watchdog_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            tx_din_q      <= tx_din_d;
            tx_send_req_q <= tx_send_req_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            watchdog_q    <= watchdog_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.tx_din      = tx_din_q;
    assign bus.tx_send_req = tx_send_req_q;

    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ack_q));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a stub transmitter driven per frame.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_SIZE = 8;
    localparam int TIMEOUT   = 120;

    logic clk;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_SIZE (DATA_SIZE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;     // cycles after LAUNCH at which the stub acks; 0 = never
        logic [1:0]  g;
        logic        err;
        bit          drop;    // client drops req right after LAUNCH
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},      32'(bus.ack), 32'd0);
        chk({tag, "_err"},      32'(bus.err), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy), 32'd0);
        chk({tag, "_grant"},    32'(bus.grant_id), 32'(NUM_REQ - 1));
        chk({tag, "_din"},      32'(bus.tx_din), 32'd0);
        chk({tag, "_send_req"}, 32'(bus.tx_send_req), 32'd0);
    endtask

    // Called in an IDLE cycle; returns in the following IDLE cycle.
    task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input int dly,
                             input logic [1:0] g, input logic err_e,
                             input bit hold, input bit spur, input bit drop);
        logic [7:0] exp_din;
        int         n, pulses, exp_cyc;
        bit         got;
        exp_din  = d[g*8 +: 8];
        exp_cyc  = (dly > 0) ? dly + 1 : TIMEOUT + 1;
        bus.req      = r;
        bus.req_data = d;
        step();
        chk("launch_grant",    32'(bus.grant_id), 32'(g));
        chk("launch_send_req", 32'(bus.tx_send_req), 32'd1);
        chk("launch_din",      32'(bus.tx_din), 32'(exp_din));
        chk("launch_busy",     32'(bus.busy), 32'd1);
        bus.req_data = ~d;
        if (drop) bus.req = '0;
        if (spur) bus.tx_send_ack = 1'b1;
        n = 0; pulses = 1; got = 0;
        while (!got && n < TIMEOUT + 10) begin
            step();
            n++;
            bus.tx_send_ack = (n == dly);
            if (bus.tx_send_req) pulses++;
            if (bus.ack != '0) got = 1;
        end
        chk("ack_cycle",      32'(n), 32'(exp_cyc));
        chk("ack_value",      32'(bus.ack), 32'(4'b0001 << g));
        chk("ack_err",        32'(bus.err), 32'(err_e));
        chk("send_req_count", 32'(pulses), 32'd1);
        chk("din_held",       32'(bus.tx_din), 32'(exp_din));
        if (!hold) bus.req[g] = 1'b0;
        if (spur) bus.tx_send_ack = 1'b1;
        step();
        bus.tx_send_ack = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_ack",  32'(bus.ack), 32'd0);
        chk("idle_err",  32'(bus.err), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.tx_send_ack = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{4'b0100, 32'h11A52233, 100,         2'd2, 1'b0, 1'b0};
        vecs[1] = '{4'b1001, 32'hC3445566, 5,           2'd3, 1'b0, 1'b0};
        vecs[2] = '{4'b1001, 32'h3C77880F, 1,           2'd0, 1'b0, 1'b1};
        vecs[3] = '{4'b0110, 32'h01027E04, 20,          2'd1, 1'b0, 1'b0};
        vecs[4] = '{4'b0001, 32'hAABBCCE0, 3,           2'd0, 1'b0, 1'b0};
        vecs[5] = '{4'b1000, 32'h99123456, 0,           2'd3, 1'b1, 1'b0};
        vecs[6] = '{4'b0010, 32'h00005A00, TIMEOUT,     2'd1, 1'b0, 1'b0};
        vecs[7] = '{4'b1111, 32'hDEADBEEF, TIMEOUT - 1, 2'd2, 1'b0, 1'b0};

        reset_n = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_send_ack = 1'b0;
        step();
        chk_reset_vals("in_reset");
        step();
        reset_n = 1'b1;
        step();
        chk_reset_vals("after_reset");

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].req, vecs[i].data, vecs[i].dly, vecs[i].g, vecs[i].err,
                      1'b0, 1'b0, vecs[i].drop);
        end
        bus.req = '0;
        step();

        // All four at once after reset: served 0,1,2,3.
        do_reset();
        run_frame(4'b1111, 32'h44332211, 7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1110, 32'h44332211, 7, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1100, 32'h44332211, 7, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1000, 32'h44332211, 7, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Rotation with client 3 holding req after its ack.
        run_frame(4'b0100, 32'h0B0A0908, 4, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1001, 32'h0B0A0908, 4, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(4'b1001, 32'h0B0A0908, 4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1000, 32'h0B0A0908, 4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req = '0;

        // Spurious ack in IDLE, then in LAUNCH and DONE of a real frame.
        bus.tx_send_ack = 1'b1;
        step();
        bus.tx_send_ack = 1'b0;
        chk("spur_idle_busy",  32'(bus.busy), 32'd0);
        chk("spur_idle_ack",   32'(bus.ack), 32'd0);
        chk("spur_idle_grant", 32'(bus.grant_id), 32'd3);
        chk("spur_idle_send",  32'(bus.tx_send_req), 32'd0);
        run_frame(4'b0010, 32'h00006600, 10, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("spur_done_send", 32'(bus.tx_send_req), 32'd0);
        step();
        chk("spur_done_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of WAIT.
        do_reset();
        bus.req = 4'b0100;
        bus.req_data = 32'h00770000;
        step();
        chk("rst_frame_launch", 32'(bus.tx_send_req), 32'd1);
        step();
        step();
        step();
        chk("rst_frame_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        step();
        step();
        reset_n = 1'b1;
        run_frame(4'b0011, 32'h0000BBAA, 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_transmitter among NUM_REQ client blocks. It latches the winning client's byte, launches a frame with a single-cycle send_req pulse, and waits for the transmitter's send_ack. It then returns a per-client completion pulse. A watchdog aborts a frame whose ack never arrives, so a client can never stall the link forever.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_SIZE, 8, payload width; must match the transmitter's DATA_SIZE
TIMEOUT, 1048575, max cycles in WAIT before abort; must exceed one frame time, (DATA_SIZE+3)*CLOCK+2
ID_W, $clog2(NUM_REQ), width of the grant index
TMO_W, $clog2(TIMEOUT+1), watchdog counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-client request, level; hold high with data stable until ack
req_data  in  NUM_REQ*DATA_SIZE  client i payload in bits [i*DATA_SIZE +: DATA_SIZE]
ack  out  NUM_REQ  one-cycle completion pulse to the granted client
err  out  1  one-cycle pulse, coincident with ack, when the frame timed out
busy  out  1  high in every state except IDLE
grant_id  out  ID_W  index of the current or last granted client
tx_din  out  DATA_SIZE  to transmitter din; held stable from LAUNCH through WAIT
tx_send_req  out  1  to transmitter send_req; exactly one-cycle pulse per frame
tx_send_ack  in  1  from transmitter send_ack, one-cycle pulse at frame end

Behaviour:
- All outputs are registered. On reset: ack=0, err=0, busy=0, grant_id=NUM_REQ-1 (so client 0 has first priority), tx_din=0, tx_send_req=0, state=IDLE, watchdog=0.
- States: IDLE, LAUNCH, WAIT, DONE. Encoding is 2 bits; unused codes go to IDLE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set bit scanning from grant_id+1 upward, wrapping modulo NUM_REQ. Load grant_id and tx_din=req_data[winner]; go to LAUNCH.
- LAUNCH: tx_send_req=1 for this cycle only; clear the watchdog; go to WAIT.
- The pulse is mandatory: the transmitter reloads on any send_req seen in its IDLE, and its send_ack arrives after it has already returned to IDLE. A level request would therefore resend the frame.
- WAIT: tx_send_req=0 and the watchdog increments each cycle.
  - tx_send_ack=1: go to DONE with err_next=0.
  - watchdog==TIMEOUT-1 with no ack: go to DONE with err_next=1.
  - Ack and expiry in the same cycle: the ack wins, err=0.
- DONE: ack[grant_id]=1 and err=err_next for this cycle; go to IDLE.
- grant_id keeps its value, which is the round-robin pointer for the next arbitration.
- Client rule: deassert req on the edge where ack is sampled high. In the next IDLE cycle req is re-sampled, so a still-high req counts as a new request.
- Latency: req rises in IDLE at cycle 0 → tx_send_req high in cycle 1 → ack cycle = cycle of tx_send_ack + 1. The bus adds 3 cycles of overhead per frame.
- tx_send_ack in IDLE, LAUNCH or DONE is spurious: it is ignored and has no effect.
- req[i] dropping during LAUNCH or WAIT does not cancel the frame; its ack is still issued.
- req_data changes after the grant cycle are ignored because tx_din is latched.
- Reset asserted mid-frame clears everything asynchronously. The transmitter is reset by the same reset_n.
- Invariant: at most one ack bit is set per cycle.

Decomposition:
- Shared uart_pkg holds the state localparams (IDLE/LAUNCH/WAIT/DONE) and a frame-cycles helper constant (DATA_SIZE+3)*CLOCK for TIMEOUT sizing.
- One sub-module, rr_priority_pick: combinational. Inputs req[NUM_REQ] and last[ID_W]; outputs any and idx[ID_W], using a rotate, find-first, un-rotate scheme.
- The FSM, watchdog and data mux live in the top.

Test Plan:
1. Single client: req=4'b0100, data2=8'hA5 → grant_id=2 at cycle 1. tx_send_req is high for exactly 1 cycle with tx_din=8'hA5. Stub acks after 100 cycles → ack=4'b0100 one cycle later, err=0.
2. All four request at once after reset → service order 0,1,2,3, one tx_send_req per frame. With the real transmitter (SYS_FREQ=50e6, BAUD_RATE=9600), the line shows 4 frames in order with matching payloads.
3. Rotation: pointer=2, req=4'b1001 → client 3 wins. Client 3 keeps req high after ack → client 0 is served next, then client 3 again.
4. Timeout: TIMEOUT=50, stub never acks → ack[winner] and err both pulse at cycle LAUNCH+51. busy drops the following cycle and the next requester is served.
5. Spurious ack: tx_send_ack pulsed while in IDLE and during LAUNCH → no ack, no state change. The frame still completes on the genuine ack.
6. Reset mid-WAIT: reset_n low for 3 cycles → outputs immediately equal reset values, grant_id=NUM_REQ-1. After release with req=4'b0011, client 0 is served first.
